// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states,
// memory write-port bundle and frame constants.
package imem_loader_pkg;

    localparam int unsigned IMEM_ADDR_W = 8;
    localparam int unsigned IMEM_DATA_W = 32;
    localparam int unsigned LEN_W       = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } LoaderState;

    typedef struct packed {
        logic                   we;
        logic [IMEM_ADDR_W-1:0] waddr;
        logic [IMEM_DATA_W-1:0] wdata;
    } Loader_imem_wr;

    // A new load may only begin once the previous one has settled.
    function automatic logic accepts_start(input LoaderState s);
        return s inside {IDLE, DONE, ERROR};
    endfunction

endpackage

// File: rtl/imem_loader_byte_to_word.sv
// Big-endian byte-to-word assembler: the first byte of a word ends up in the
// top byte, and word_valid pulses for one cycle after the fourth byte.
module imem_loader_byte_to_word
    import imem_loader_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   byte_valid_i,
    input  logic [7:0]             byte_i,
    output logic                   last_byte_o,
    output logic                   word_valid_o,
    output logic [IMEM_DATA_W-1:0] word_o
);

    logic [1:0]             cnt_q, cnt_d;
    logic [IMEM_DATA_W-1:0] shift_q, shift_d;
    logic                   valid_q, valid_d;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        if (clr_i) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_valid_i) begin
            shift_d = {shift_q[IMEM_DATA_W-9:0], byte_i};
            cnt_d   = cnt_q + 2'd1;
            valid_d = (cnt_q == 2'd3);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
        end
    end

    assign last_byte_o  = (cnt_q == 2'd3);
    assign word_valid_o = valid_q;
    assign word_o       = shift_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte frame into the
// instruction memory and keeps the core in reset until the image verifies.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = IMEM_ADDR_W,
    parameter int unsigned DATA_W = IMEM_DATA_W,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

    localparam logic [LEN_W:0] DepthLim = (LEN_W + 1)'(DEPTH);

    LoaderState        state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        chk_q, chk_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              core_rst_q, core_rst_d;

    logic                   accept;
    logic                   start_ok;
    logic                   last_byte;
    logic                   word_valid;
    logic [IMEM_DATA_W-1:0] word;
    logic [LEN_W-1:0]       len_full;
    Loader_imem_wr          imem_wr;

    assign accept   = in_valid & in_ready;
    assign start_ok = start & accepts_start(state_q);
    assign len_full = {len_q[LEN_W-1:8], in_data};

    imem_loader_byte_to_word u_b2w (
        .clk_i        (clk),
        .rst_i        (rst),
        .clr_i        (start_ok),
        .byte_valid_i (accept && (state_q == DATA)),
        .byte_i       (in_data),
        .last_byte_o  (last_byte),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            waddr_q    <= '0;
            chk_q      <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            waddr_q    <= waddr_d;
            chk_q      <= chk_d;
            done_q     <= done_d;
            error_q    <= error_d;
            core_rst_q <= core_rst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERROR: if (start) state_d = LEN_HI;
            LEN_HI:            if (accept) state_d = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if ({1'b0, len_full} > DepthLim) state_d = ERROR;
                    else if (len_full == '0)         state_d = CHECK;
                    else                             state_d = DATA;
                end
            end
            DATA: begin
                if (accept && last_byte && (word_cnt_q == len_q - 16'd1)) state_d = CHECK;
            end
            CHECK: if (accept) state_d = (in_data == chk_q) ? DONE : ERROR;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        len_d      = len_q;
        chk_d      = chk_q;
        word_cnt_d = word_cnt_q;
        waddr_d    = waddr_q;
        if (start_ok) begin
            len_d      = '0;
            chk_d      = '0;
            word_cnt_d = '0;
        end else if (accept) begin
            case (state_q)
                LEN_HI: len_d[LEN_W-1:8] = in_data;
                LEN_LO: len_d[7:0] = in_data;
                DATA: begin
                    chk_d = chk_q ^ in_data;
                    // Latch the address alongside the completing byte so it lines up with we.
                    if (last_byte) begin
                        waddr_d    = word_cnt_q[ADDR_W-1:0];
                        word_cnt_d = word_cnt_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready   = state_q inside {LEN_HI, LEN_LO, DATA, CHECK};
        done_d     = (state_d == DONE);
        error_d    = (state_d == ERROR);
        core_rst_d = (state_d != DONE);
    end

    assign imem_wr  = '{we: word_valid, waddr: waddr_q, wdata: word};
    assign we       = imem_wr.we;
    assign waddr    = imem_wr.waddr;
    assign wdata    = imem_wr.wdata;
    assign done     = done_q;
    assign error    = error_q;
    assign core_rst = core_rst_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected memory writes go to a scoreboard
// queue when their 4th byte is driven and are popped when we pulses.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, we, core_rst, done, error;
    logic [7:0]  waddr;
    logic [31:0] wdata;

    imem_loader #(
        .ADDR_W (8),
        .DATA_W (32),
        .DEPTH  (256)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .core_rst (core_rst),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] img[$];
    logic [31:0] tw;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_we", {31'b0, we}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("waddr", {24'b0, waddr}, {24'b0, mon_e.addr});
                check("wdata", wdata, mon_e.data);
                check("we_latency", cyc, mon_e.cyc);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
        check({tag, "_we"}, {31'b0, we}, 32'd0);
        check({tag, "_waddr"}, {24'b0, waddr}, 32'd0);
        check({tag, "_wdata"}, wdata, 32'd0);
        check({tag, "_core_rst"}, {31'b0, core_rst}, 32'd1);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_error"}, {31'b0, error}, 32'd0);
    endtask

    task automatic check_status(input string tag, input bit exp_done, input bit exp_error);
        check({tag, "_done"}, {31'b0, done}, {31'b0, exp_done});
        check({tag, "_error"}, {31'b0, error}, {31'b0, exp_error});
        check({tag, "_core_rst"}, {31'b0, core_rst}, {31'b0, !exp_done});
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
        check({tag, "_sb_empty"}, exp_q.size(), 32'd0);
    endtask

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send_byte(input logic [7:0] b, input bit stall, input bit push,
                             input logic [7:0] addr, input logic [31:0] word);
        int n;
        if (stall) begin
            while ($urandom_range(0, 1) == 1) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", {31'b0, in_ready}, 32'd1);
        if (in_ready === 1'b1 && push) exp_q.push_back('{addr, word, cyc + 1});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load(input bit stall, input bit bad_chk);
        logic [7:0]  chk;
        logic [7:0]  b;
        logic [15:0] len;
        logic [31:0] w;
        chk = 8'h00;
        len = 16'(img.size());
        send_byte(len[15:8], stall, 1'b0, 8'h00, 32'h0);
        send_byte(len[7:0], stall, 1'b0, 8'h00, 32'h0);
        for (int i = 0; i < img.size(); i++) begin
            w = img[i];
            for (int j = 0; j < 4; j++) begin
                b   = w[31 - 8 * j -: 8];
                chk = chk ^ b;
                send_byte(b, stall, j == 3, 8'(i), w);
            end
        end
        send_byte(bad_chk ? (chk ^ 8'h01) : chk, stall, 1'b0, 8'h00, 32'h0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // Two-word image; payload XOR is 0x22.
        img = '{32'h3C010005, 32'h00221820};
        pulse_start();
        check("a_core_rst_loading", {31'b0, core_rst}, 32'd1);
        check("a_in_ready_len", {31'b0, in_ready}, 32'd1);
        load(1'b0, 1'b0);
        check_status("a", 1'b1, 1'b0);

        // Empty image: only the checksum byte follows the length.
        img.delete();
        pulse_start();
        check("z_core_rst_restart", {31'b0, core_rst}, 32'd1);
        check("z_done_cleared", {31'b0, done}, 32'd0);
        load(1'b0, 1'b0);
        check_status("z", 1'b1, 1'b0);

        // N = 0x0101 exceeds DEPTH; nothing more may be accepted.
        pulse_start();
        send_byte(8'h01, 1'b0, 1'b0, 8'h00, 32'h0);
        send_byte(8'h01, 1'b0, 1'b0, 8'h00, 32'h0);
        check_status("len", 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = 8'hAA;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("len_no_accept", {31'b0, in_ready}, 32'd0);
            check("len_core_rst", {31'b0, core_rst}, 32'd1);
        end
        in_valid = 1'b0;

        // Wrong checksum: words are still written, then error.
        img = '{32'h3C010005, 32'h00221820};
        pulse_start();
        check("chk_error_cleared", {31'b0, error}, 32'd0);
        load(1'b0, 1'b1);
        check_status("chk", 1'b0, 1'b1);

        // 16 random words with random in_valid gaps.
        img.delete();
        for (int i = 0; i < 16; i++) img.push_back($urandom());
        pulse_start();
        load(1'b1, 1'b0);
        check_status("rnd", 1'b1, 1'b0);

        // Reset after 6 payload bytes, then a clean reload from address 0.
        img = '{32'h3C010005, 32'h00221820};
        pulse_start();
        send_byte(8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
        send_byte(8'h02, 1'b0, 1'b0, 8'h00, 32'h0);
        for (int j = 0; j < 6; j++) begin
            tw = img[j / 4];
            send_byte(tw[31 - 8 * (j % 4) -: 8], 1'b0, j == 3, 8'h00, tw);
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        rst = 1'b0;
        @(negedge clk);
        pulse_start();
        load(1'b0, 1'b0);
        check_status("reload", 1'b1, 1'b0);

        repeat (3) @(negedge clk);
        check("final_sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
